// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined core's memory-side blocks.
// Covers the RAM handshake encoding and the cache/RAM arbiter state.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_watchdog.sv
// Service-time watchdog for the cache/RAM arbiter: counts cycles spent
// in a service state and flags when the limit is reached.
module arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLIMIT = TW'(TIMEOUT);

    logic [TW-1:0] timer;

    // Holds at the limit so a stalled requester can never wrap the count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (count_en && !expired) begin
            timer <= timer + TW'(1);
        end
    end

    assign expired = (timer == TLIMIT);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single RAM port between the icache miss path and the
// dcache miss/writeback path; data wins unless fetch has been starved.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255,
    parameter int AW         = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic [AW-1:0] iload,
    output logic          iwait,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [AW-1:0] dstore,
    output logic [AW-1:0] dload,
    output logic          dwait,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [AW-1:0] ramstore,
    input  logic [AW-1:0] ramload,
    input  logic [1:0]    ramstate,
    output logic          bus_error
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_SAT = SW'(STARVE_MAX);

    arb_state_t    state;
    logic [SW-1:0] streak;
    ramstate_t     rs;
    logic          d_req;
    logic          serv_req;
    logic          expired;
    logic          timed_out;
    logic          finish;
    logic          set_error;

    assign rs    = ramstate_t'(ramstate);
    assign d_req = dREN | dWEN;

    // The request belonging to whoever currently holds the grant.
    always_comb begin
        serv_req = 1'b0;
        unique case (state)
            DSERV:   serv_req = d_req;
            ISERV:   serv_req = iREN;
            default: serv_req = 1'b0;
        endcase
    end

    assign timed_out = (state != IDLE) && expired && (rs != ACCESS) && (rs != ERROR);
    assign finish    = serv_req && ((rs == ACCESS) || (rs == ERROR) || timed_out);
    assign set_error = ((state == DSERV) && dREN && dWEN)
                     || (serv_req && ((rs == ERROR) || timed_out));

    arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (state == IDLE),
        .count_en (state != IDLE),
        .expired  (expired)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            streak    <= '0;
            bus_error <= 1'b0;
        end else begin
            if (set_error) begin
                bus_error <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (d_req && !(iREN && (streak == STREAK_SAT))) begin
                        state  <= DSERV;
                        streak <= iREN ? streak + SW'(1) : '0;
                    end else if (iREN) begin
                        state  <= ISERV;
                        streak <= '0;
                    end
                end
                DSERV, ISERV: begin
                    if (!serv_req || finish) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        unique case (state)
            DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dload    = timed_out ? '0 : ramload;
                dwait    = ~finish;
            end
            ISERV: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iload   = timed_out ? '0 : ramload;
                iwait   = ~finish;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus random
// requester traffic, all compared against a transaction-level model.
module tb_cache_mem_arbiter;

    localparam int AW   = 32;
    localparam int SMAX = 4;
    localparam int TMO  = 8;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    localparam int G_NONE  = 0;
    localparam int G_DATA  = 1;
    localparam int G_INSTR = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [AW-1:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]    ramstate = RS_FREE;
    logic [AW-1:0] iload, dload, ramaddr, ramstore;
    logic          iwait, dwait, ramREN, ramWEN, bus_error;

    cache_mem_arbiter #(
        .STARVE_MAX (SMAX),
        .TIMEOUT    (TMO),
        .AW         (AW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .iREN      (iREN),
        .iaddr     (iaddr),
        .iload     (iload),
        .iwait     (iwait),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dload     (dload),
        .dwait     (dwait),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate),
        .bus_error (bus_error)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: who holds the grant, how long it has been served,
    // consecutive data grants while fetch waited, sticky error.
    int m_grant = G_NONE;
    int m_svc   = 0;
    int m_streak = 0;
    bit m_err   = 1'b0;

    // Snapshot of DUT outputs at the last sample point, plus pulse counters.
    logic [AW-1:0] s_addr, s_store, s_iload, s_dload;
    logic          s_iwait, s_dwait, s_ren, s_wen, s_err;
    int n_ilow, n_dlow, n_ren, n_wen;
    int order[$];

    task automatic clr_obs();
        n_ilow = 0; n_dlow = 0; n_ren = 0; n_wen = 0;
        order.delete();
    endtask

    task automatic compare();
        logic          e_ren, e_wen, e_iwait, e_dwait;
        logic [AW-1:0] e_addr, e_store, e_iload, e_dload;
        bit acc, er, forced, fin;
        e_ren = 1'b0; e_wen = 1'b0; e_iwait = 1'b1; e_dwait = 1'b1;
        e_addr = '0; e_store = '0; e_iload = '0; e_dload = '0;
        acc    = (ramstate == RS_ACCESS);
        er     = (ramstate == RS_ERROR);
        forced = (m_grant != G_NONE) && (m_svc == TMO) && !acc && !er;
        if (m_grant == G_DATA) begin
            fin     = (dREN || dWEN) && (acc || er || forced);
            e_addr  = daddr;
            e_store = dstore;
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
            e_dwait = !fin;
            e_dload = forced ? '0 : ramload;
        end else if (m_grant == G_INSTR) begin
            fin     = iREN && (acc || er || forced);
            e_addr  = iaddr;
            e_ren   = iREN;
            e_iwait = !fin;
            e_iload = forced ? '0 : ramload;
        end
        check("ramREN",    AW'(ramREN),    AW'(e_ren));
        check("ramWEN",    AW'(ramWEN),    AW'(e_wen));
        check("ramaddr",   ramaddr,        e_addr);
        check("ramstore",  ramstore,       e_store);
        check("iwait",     AW'(iwait),     AW'(e_iwait));
        check("dwait",     AW'(dwait),     AW'(e_dwait));
        check("iload",     iload,          e_iload);
        check("dload",     dload,          e_dload);
        check("bus_error", AW'(bus_error), AW'(m_err));
        s_addr = ramaddr; s_store = ramstore; s_iload = iload; s_dload = dload;
        s_iwait = iwait; s_dwait = dwait; s_ren = ramREN; s_wen = ramWEN; s_err = bus_error;
        if (!iwait) begin n_ilow++; order.push_back(G_INSTR); end
        if (!dwait) begin n_dlow++; order.push_back(G_DATA); end
        if (ramREN) n_ren++;
        if (ramWEN) n_wen++;
    endtask

    task automatic advance();
        bit dq, req, acc, er, forced;
        dq = dREN || dWEN;
        if (m_grant == G_NONE) begin
            if (dq && !(iREN && m_streak >= SMAX)) begin
                m_grant  = G_DATA;
                m_svc    = 0;
                m_streak = iREN ? ((m_streak + 1 > SMAX) ? SMAX : m_streak + 1) : 0;
            end else if (iREN) begin
                m_grant  = G_INSTR;
                m_svc    = 0;
                m_streak = 0;
            end
        end else begin
            req    = (m_grant == G_DATA) ? dq : iREN;
            acc    = (ramstate == RS_ACCESS);
            er     = (ramstate == RS_ERROR);
            forced = (m_svc == TMO) && !acc && !er;
            if (m_grant == G_DATA && dREN && dWEN) m_err = 1'b1;
            if (req && (er || forced)) m_err = 1'b1;
            if (!req || acc || er || forced) m_grant = G_NONE;
            else m_svc++;
        end
    endtask

    task automatic step(input logic i_r, input logic [AW-1:0] i_a,
                        input logic d_r, input logic d_w,
                        input logic [AW-1:0] d_a, input logic [AW-1:0] d_s,
                        input logic [AW-1:0] r_l, input logic [1:0] r_s);
        @(negedge CLK);
        iREN = i_r; iaddr = i_a; dREN = d_r; dWEN = d_w;
        daddr = d_a; dstore = d_s; ramload = r_l; ramstate = r_s;
        #1;
        compare();
        @(posedge CLK);
        advance();
    endtask

    task automatic idle_step();
        step(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, RS_FREE);
    endtask

    // Asserts reset mid-cycle (requests left as they are) and checks the
    // outputs collapse to their reset values before the next clock edge.
    task automatic reset_now();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("rst_ramREN",    AW'(ramREN),    '0);
        check("rst_ramWEN",    AW'(ramWEN),    '0);
        check("rst_ramaddr",   ramaddr,        '0);
        check("rst_ramstore",  ramstore,       '0);
        check("rst_iwait",     AW'(iwait),     AW'(1));
        check("rst_dwait",     AW'(dwait),     AW'(1));
        check("rst_iload",     iload,          '0);
        check("rst_dload",     dload,          '0);
        check("rst_bus_error", AW'(bus_error), '0);
        m_grant = G_NONE; m_svc = 0; m_streak = 0; m_err = 1'b0;
        @(negedge CLK);
        RST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = RS_FREE;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bit            i_pend, d_pend, d_w;
        logic [AW-1:0] i_a, d_a, d_s;
        logic [1:0]    r_s;
        int            r, low_at;
        logic [AW-1:0] a1, a2, low_dload;
        logic          t_ren, t_iwait;

        reset_now();

        // Lone icache read.
        clr_obs();
        step(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, '0, RS_BUSY);
        step(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, '0, RS_BUSY);
        step(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, 32'hDEADBEEF, RS_ACCESS);
        a1 = s_iload;
        idle_step();
        check("iread_iload", a1, 32'hDEADBEEF);
        check("iread_ilow_cycles", AW'(n_ilow), AW'(1));
        check("iread_ren_cycles", AW'(n_ren), AW'(2));

        // Simultaneous requests: data first, one turnaround cycle, then fetch.
        reset_now();
        clr_obs();
        step(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0, '0, RS_BUSY);
        step(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, '0, 32'h11, RS_ACCESS);
        a1 = s_addr;
        step(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, '0, RS_BUSY);
        t_ren = s_ren; t_iwait = s_iwait;
        step(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, 32'h22, RS_ACCESS);
        a2 = s_addr;
        idle_step();
        check("simul_first_addr", a1, 32'h200);
        check("simul_turnaround_ren", AW'(t_ren), '0);
        check("simul_turnaround_iwait", AW'(t_iwait), AW'(1));
        check("simul_second_addr", a2, 32'h100);
        check("simul_pulses", AW'(n_ilow + n_dlow), AW'(2));

        // Starvation: four data grants, then fetch, then data again.
        reset_now();
        clr_obs();
        for (int k = 0; k < 12; k++)
            step(1'b1, 32'h300, 1'b1, 1'b0, 32'h400, '0, AW'(k), RS_ACCESS);
        idle_step();
        check("starve_grants", AW'(order.size()), AW'(6));
        if (order.size() == 6) begin
            for (int k = 0; k < 4; k++) check("starve_data_first", AW'(order[k]), AW'(G_DATA));
            check("starve_fetch_fifth", AW'(order[4]), AW'(G_INSTR));
            check("starve_streak_cleared", AW'(order[5]), AW'(G_DATA));
        end

        // Write with three BUSY cycles.
        reset_now();
        clr_obs();
        step(1'b0, '0, 1'b0, 1'b1, 32'h80, 32'h12345678, '0, RS_FREE);
        step(1'b0, '0, 1'b0, 1'b1, 32'h80, 32'h12345678, '0, RS_BUSY);
        a1 = s_store;
        step(1'b0, '0, 1'b0, 1'b1, 32'h80, 32'h12345678, '0, RS_BUSY);
        step(1'b0, '0, 1'b0, 1'b1, 32'h80, 32'h12345678, '0, RS_BUSY);
        step(1'b0, '0, 1'b0, 1'b1, 32'h80, 32'h12345678, '0, RS_ACCESS);
        idle_step();
        check("write_wen_cycles", AW'(n_wen), AW'(4));
        check("write_ramstore", a1, 32'h12345678);
        check("write_dlow_cycles", AW'(n_dlow), AW'(1));

        // Random traffic from both requesters.
        reset_now();
        i_pend = 1'b0; d_pend = 1'b0; d_w = 1'b0;
        i_a = '0; d_a = '0; d_s = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!i_pend && $urandom_range(3) == 0) begin i_pend = 1'b1; i_a = $urandom; end
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend = 1'b1; d_w = 1'($urandom_range(1)); d_a = $urandom; d_s = $urandom;
            end
            if (i_pend && $urandom_range(63) == 0) i_pend = 1'b0;
            if (d_pend && $urandom_range(63) == 0) d_pend = 1'b0;
            r = int'($urandom_range(99));
            r_s = (r < 40) ? RS_BUSY : (r < 48) ? RS_FREE : (r < 99) ? RS_ACCESS : RS_ERROR;
            step(i_pend, i_pend ? i_a : $urandom, d_pend && !d_w, d_pend && d_w,
                 d_a, d_s, $urandom, r_s);
            if (!s_iwait) i_pend = 1'b0;
            if (!s_dwait) d_pend = 1'b0;
        end

        // Illegal read+write together: write wins, error latches.
        reset_now();
        step(1'b0, '0, 1'b1, 1'b1, 32'h90, 32'hCAFE, '0, RS_FREE);
        step(1'b0, '0, 1'b1, 1'b1, 32'h90, 32'hCAFE, '0, RS_ACCESS);
        t_ren = s_ren; a1 = AW'(s_wen);
        idle_step();
        check("illegal_ren", AW'(t_ren), '0);
        check("illegal_wen", a1, AW'(1));
        check("illegal_bus_error", AW'(s_err), AW'(1));

        // Watchdog: BUSY forever forces completion on the ninth service cycle.
        reset_now();
        clr_obs();
        low_at = 0; low_dload = 32'hFFFFFFFF;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, '0, 1'b1, 1'b0, 32'hC0, '0, 32'hA5A5A5A5, RS_BUSY);
            if (!s_dwait && low_at == 0) begin low_at = k; low_dload = s_dload; end
        end
        for (int k = 0; k < 4; k++) idle_step();
        check("timeout_cycle", AW'(low_at), AW'(10));
        check("timeout_dload", low_dload, '0);
        check("timeout_pulses", AW'(n_dlow), AW'(1));
        check("timeout_sticky_error", AW'(s_err), AW'(1));

        // Reset during a data service aborts it in the same cycle.
        step(1'b0, '0, 1'b1, 1'b0, 32'hE0, '0, '0, RS_FREE);
        step(1'b0, '0, 1'b1, 1'b0, 32'hE0, '0, '0, RS_BUSY);
        check("midreset_pre_ren", AW'(s_ren), AW'(1));
        reset_now();
        idle_step();
        check("midreset_post_error", AW'(s_err), '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single RAM port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined core.
- Sits between the two caches and the RAM model. It grants one requester at a time and holds the grant until the RAM signals completion.
- Data has fixed priority, bounded by an anti-starvation counter for instruction fetch.
- A watchdog flags accesses that never complete.

Parameters:
- STARVE_MAX, 4: max consecutive data grants while an instruction request waits.
- TIMEOUT, 255: max cycles in a service state before a forced abort.
- AW, 32: address/data width.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- iREN  in  1  icache read request; held stable until iwait drops.
- iaddr  in  AW  icache word address.
- iload  out  AW  read data to icache.
- iwait  out  1  1 = icache must keep waiting.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  AW  dcache address.
- dstore  in  AW  dcache write data.
- dload  out  AW  read data to dcache.
- dwait  out  1  1 = dcache must keep waiting.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  AW  RAM address.
- ramstore  out  AW  RAM write data.
- ramload  in  AW  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- bus_error  out  1  sticky error flag.

Behaviour:
Reset (RST=1, async) and reset values:
- State is IDLE; streak counter and timer are 0; bus_error=0.
- Outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
- Asserting reset mid-access aborts that access immediately with no completion pulse.

States: IDLE, DSERV, ISERV.

IDLE:
- Drives no RAM strobes; iwait=dwait=1.
- Next state:
  - DSERV if (dREN|dWEN) and not (iREN and streak==STARVE_MAX).
  - Otherwise ISERV if iREN.
  - Otherwise stay in IDLE.
- When ISERV is entered, streak resets to 0.
- When DSERV is entered with iREN=1, streak increments (saturating at STARVE_MAX).
- When DSERV is entered with iREN=0, streak clears to 0.

DSERV:
- ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN & ~dWEN.
- dREN&dWEN together is illegal: the write is performed and bus_error is set.
- dload=ramload; iwait=1.

ISERV:
- ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- iload=ramload; dwait=1.

Completion:
- In a service state, ramstate==ACCESS drops the served wait to 0 combinationally for exactly that cycle, then the FSM returns to IDLE.
- Minimum request-to-completion is 2 cycles (IDLE decision, then service with immediate ACCESS).
- Back-to-back grants always pass through one IDLE cycle, which is the bus turnaround.

Error:
- ramstate==ERROR in a service state completes the access like ACCESS (wait drops, returns to IDLE) and sets bus_error.

Withdrawal:
- If the served requester drops its request before completion, strobes go low that cycle, the FSM returns to IDLE, and no wait pulse is issued.

Watchdog:
- Timer clears on entering a service state and increments each cycle while in it.
- At timer==TIMEOUT without ACCESS or ERROR: force completion (wait pulse, load data=0), set bus_error, return to IDLE.

bus_error:
- Clears only on reset.

Simultaneous events:
- iREN and dREN in the same IDLE cycle go to data unless the streak has saturated.
- A request arriving during a service state is not considered until IDLE.

Decomposition:
- cpu_types_pkg gains:
  - ramstate_t enum: FREE, BUSY, ACCESS, ERROR.
  - arb_state_t enum: IDLE, DSERV, ISERV.
- word_t is reused for all AW buses.
- One natural sub-module: arb_watchdog. It holds the timer compare (inputs: clear, count enable; output: expired).

Test Plan:
- Lone icache read: iREN=1, iaddr=0x40, RAM returns ACCESS one cycle after ISERV with ramload=0xDEADBEEF -> iwait low for exactly one cycle with iload=0xDEADBEEF; ramREN high only in ISERV.
- Simultaneous requests: iREN=dREN=1 from reset -> data is served first, IDLE for one cycle, then instruction is served; ramaddr switches daddr->iaddr.
- Starvation: dREN held continuously with iREN=1, STARVE_MAX=4 -> four data grants, then the fifth grant is ISERV; streak reads 0 afterwards.
- Write: dWEN=1, daddr=0x80, dstore=0x12345678, RAM BUSY for 3 cycles then ACCESS -> ramWEN=1 for 4 cycles, ramstore=0x12345678, one dwait-low cycle.
- Timeout: ramstate held BUSY, TIMEOUT=8 -> forced completion on the 9th service cycle with dload=0; bus_error=1 and stays set until RST.
- Reset mid-access: RST asserted during DSERV -> same cycle ramREN=ramWEN=0, dwait=1, state IDLE, bus_error=0.
